fifo_serializer: RTL and testbench

- Drain stage that sits directly downstream of generic_fifo.
- Pops one word at a time from the FIFO and shifts it out MSB-first on a 1-bit valid/ready serial interface.
- Optionally appends an even-parity bit after each word.
- Keeps a running count of completed words for status and debug.

---
 rtl/fifo_serializer.sv | 121 ++++++++++++
 tb/tb_fifo_serializer.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_serializer.sv
// fifo_serializer
//
// Drain stage placed directly after generic_fifo. Pops one word at a time,
// shifts it out MSB-first on a 1-bit valid/ready link, optionally appends an
// even-parity bit, and counts completed words.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | nothing in flight; pops as soon as the FIFO is non-empty
// S_WAIT  | FIFO data becomes valid this cycle; load shift register
// S_SHIFT | presenting bits; advance on each valid&ready transfer
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous reset, active low
//   in           FIFO read data, valid the cycle after read
//   empty        FIFO empty flag
//   read         FIFO pop strobe, one cycle per word
//   ser_out      current serial bit
//   ser_valid    ser_out holds a valid bit
//   ser_ready    consumer accepts the bit this cycle
//   frame_start  first bit of a word is being presented
//   busy         any state other than S_IDLE
//   word_count   completed words (parity bit included), wraps at 256

module fifo_serializer #(
    parameter int MSB       = 3,
    parameter int LSB       = 0,
    parameter int PARITY_EN = 0
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [MSB:LSB] in,
    input  logic           empty,
    output logic           read,
    output logic           ser_out,
    output logic           ser_valid,
    input  logic           ser_ready,
    output logic           frame_start,
    output logic           busy,
    output logic [7:0]     word_count
);

    localparam int W  = MSB - LSB + 1;
    localparam int N  = W + ((PARITY_EN != 0) ? 1 : 0);
    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_SHIFT
    } state_t;

    state_t        state;
    logic [N-1:0]  shreg;
    logic [CW-1:0] bit_cnt;
    logic [N-1:0]  load_val;
    logic          xfer;
    logic          last_xfer;

    // The parity bit rides in the LSB position of the shift register so it
    // naturally falls out right after the data LSB.
    generate
        if (PARITY_EN != 0) begin : g_par
            assign load_val = {in, ^in};
        end else begin : g_nopar
            assign load_val = in;
        end
    endgenerate

    assign xfer      = (state == S_SHIFT) && ser_ready;
    assign last_xfer = xfer && (bit_cnt == LAST_BIT);

    // Pop is combinational so a new word can be requested in the same cycle
    // the previous one finishes, leaving only the single S_WAIT bubble.
    // Gating with reset keeps the strobe quiet while reset is held.
    assign read = reset && !empty && ((state == S_IDLE) || last_xfer);

    // Serial-side outputs decode only registered state, never inputs.
    assign ser_valid   = (state == S_SHIFT);
    assign ser_out     = ser_valid && shreg[N-1];
    assign frame_start = ser_valid && (bit_cnt == '0);
    assign busy        = (state != S_IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            shreg      <= '0;
            bit_cnt    <= '0;
            word_count <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!empty) begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    shreg   <= load_val;
                    bit_cnt <= '0;
                    state   <= S_SHIFT;
                end
                S_SHIFT: begin
                    if (ser_ready) begin
                        shreg   <= shreg << 1;
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == LAST_BIT) begin
                            word_count <= word_count + 8'd1;
                            state      <= empty ? S_IDLE : S_WAIT;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_serializer.sv
// Testbench for fifo_serializer: two instances (no parity / parity) fed
// by FIFO models, checked every cycle against a bit-stream reference model.

module tb_fifo_serializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       ser_ready;
    logic [3:0] din [2];
    logic [1:0] emp;

    logic rd0, rd1, so0, so1, sv0, sv1, fs0, fs1, bz0, bz1;
    logic [7:0] wc0, wc1;

    wire [1:0]  rd_v = {rd1, rd0};
    wire [1:0]  so_v = {so1, so0};
    wire [1:0]  sv_v = {sv1, sv0};
    wire [1:0]  fs_v = {fs1, fs0};
    wire [1:0]  bz_v = {bz1, bz0};
    wire [15:0] wc_p = {wc1, wc0};

    fifo_serializer #(.MSB(3), .LSB(0), .PARITY_EN(0)) u_nopar (
        .clk(clk), .reset(reset), .in(din[0]), .empty(emp[0]), .read(rd0),
        .ser_out(so0), .ser_valid(sv0), .ser_ready(ser_ready),
        .frame_start(fs0), .busy(bz0), .word_count(wc0)
    );

    fifo_serializer #(.MSB(3), .LSB(0), .PARITY_EN(1)) u_par (
        .clk(clk), .reset(reset), .in(din[1]), .empty(emp[1]), .read(rd1),
        .ser_out(so1), .ser_valid(sv1), .ser_ready(ser_ready),
        .frame_start(fs1), .busy(bz1), .word_count(wc1)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // FIFO model (driver side)
    logic [3:0] mem [2][0:4095];
    int         wr_ptr [2];
    int         rd_ptr [2];
    int         npops  [2];
    logic [1:0] pop_smp;

    // Reference model (compare side)
    bit         stream [2][0:8191];
    int         s_head [2];
    int         s_tail [2];
    int         cur_left [2];
    int         cur_pos  [2];
    bit         wait_now [2];
    logic [7:0] m_wc [2];
    int         m_rd [2];
    logic [31:0] cap [2];
    int          ncap [2];

    logic v_e, b_e, x_e, l_e, r_e;
    logic [3:0] mw;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Compare process: model of what each instance must show this cycle.
    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (!reset) begin
                    cur_left[i] = 0; cur_pos[i] = 0; wait_now[i] = 0;
                    m_wc[i] = 8'd0; s_head[i] = 0; s_tail[i] = 0;
                    m_rd[i] = rd_ptr[i]; cap[i] = 0; ncap[i] = 0;
                end else begin
                    v_e = (cur_left[i] > 0);
                    b_e = v_e || wait_now[i];
                    x_e = v_e && ser_ready;
                    l_e = x_e && (cur_left[i] == 1);
                    r_e = !emp[i] && (!b_e || l_e);
                    chk($sformatf("ser_valid[%0d]", i), 32'(sv_v[i]), 32'(v_e));
                    chk($sformatf("busy[%0d]", i), 32'(bz_v[i]), 32'(b_e));
                    chk($sformatf("read[%0d]", i), 32'(rd_v[i]), 32'(r_e));
                    chk($sformatf("word_count[%0d]", i), 32'(wc_p[i*8 +: 8]), 32'(m_wc[i]));
                    chk($sformatf("frame_start[%0d]", i), 32'(fs_v[i]),
                        32'(v_e && (cur_pos[i] == 0)));
                    if (v_e)
                        chk($sformatf("ser_out[%0d]", i), 32'(so_v[i]), 32'(stream[i][s_head[i]]));
                    if (sv_v[i] && ser_ready) begin
                        cap[i] = {cap[i][30:0], so_v[i]};
                        ncap[i]++;
                    end
                    if (x_e) begin
                        s_head[i]++;
                        cur_pos[i]++;
                        cur_left[i]--;
                        if (cur_left[i] == 0) m_wc[i] = m_wc[i] + 8'd1;
                    end
                    if (wait_now[i]) begin
                        cur_left[i] = 4 + i;
                        cur_pos[i]  = 0;
                    end
                    wait_now[i] = r_e;
                    if (r_e) begin
                        mw = mem[i][m_rd[i]];
                        m_rd[i]++;
                        for (int b = 3; b >= 0; b--) begin
                            stream[i][s_tail[i]] = mw[b];
                            s_tail[i]++;
                        end
                        if (i == 1) begin
                            stream[i][s_tail[i]] = ^mw;
                            s_tail[i]++;
                        end
                    end
                end
            end
        end
    end

    task automatic upd_empty();
        for (int i = 0; i < 2; i++) emp[i] = (rd_ptr[i] == wr_ptr[i]);
    endtask

    task automatic push(input logic [3:0] w);
        for (int i = 0; i < 2; i++) begin
            mem[i][wr_ptr[i]] = w;
            wr_ptr[i]++;
        end
        upd_empty();
    endtask

    // One clock: sample pops at negedge, apply FIFO update just after posedge.
    task automatic cycle();
        @(negedge clk);
        pop_smp = rd_v;
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            if (pop_smp[i]) begin
                din[i] = mem[i][rd_ptr[i]];
                rd_ptr[i]++;
                npops[i]++;
            end
        end
        upd_empty();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        chk("rst read", 32'(rd_v), 32'd0);
        chk("rst ser_valid", 32'(sv_v), 32'd0);
        chk("rst ser_out", 32'(so_v), 32'd0);
        chk("rst frame_start", 32'(fs_v), 32'd0);
        chk("rst busy", 32'(bz_v), 32'd0);
        chk("rst word_count", 32'(wc_p), 32'd0);
        for (int i = 0; i < 2; i++) begin
            rd_ptr[i] = wr_ptr[i];
            npops[i]  = 0;
        end
        upd_empty();
        pop_smp = 2'b00;
        cycle();
        cycle();
        reset = 1'b1;
    endtask

    task automatic wait_idle(input int limit, input string name);
        int k;
        k = 0;
        while (!(emp == 2'b11 && bz_v == 2'b00) && k < limit) begin
            cycle();
            k++;
        end
        cycle();
        chk({name, " drain"}, 32'(k < limit), 32'd1);
    endtask

    initial begin
        int k;
        int pushed;
        reset     = 1'b0;
        ser_ready = 1'b0;
        emp       = 2'b11;
        din[0]    = 4'd0;
        din[1]    = 4'd0;
        pop_smp   = 2'b00;
        for (int i = 0; i < 2; i++) begin
            wr_ptr[i] = 0; rd_ptr[i] = 0; npops[i] = 0;
        end
        do_reset();

        // idle with empty FIFO
        ser_ready = 1'b1;
        repeat (10) cycle();
        chk("idle pops0", 32'(npops[0]), 32'd0);
        chk("idle pops1", 32'(npops[1]), 32'd0);
        chk("idle busy", 32'(bz_v), 32'd0);
        chk("idle wc", 32'(wc_p), 32'd0);

        // single word 1011
        do_reset();
        push(4'b1011);
        wait_idle(50, "t2");
        chk("t2 bits0", cap[0], 32'hB);
        chk("t2 nbits0", 32'(ncap[0]), 32'd4);
        chk("t2 bits1", cap[1], 32'h17);
        chk("t2 nbits1", 32'(ncap[1]), 32'd5);
        chk("t2 wc", 32'(wc_p), 32'h0101);
        chk("t2 pops0", 32'(npops[0]), 32'd1);

        // two words with parity
        do_reset();
        push(4'b1011);
        push(4'b0110);
        wait_idle(50, "t3");
        chk("t3 bits0", cap[0], 32'hB6);
        chk("t3 bits1", cap[1], 32'h2EC);
        chk("t3 wc", 32'(wc_p), 32'h0202);

        // backpressure after first bit
        do_reset();
        push(4'b1011);
        k = 0;
        while (ncap[0] < 1 && k < 20) begin cycle(); k++; end
        chk("t4 start", 32'(k < 20), 32'd1);
        ser_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            cycle();
            chk("t4 hold valid", 32'(sv_v), 32'd3);
            chk("t4 hold out", 32'(so_v), 32'd0);
        end
        ser_ready = 1'b1;
        wait_idle(50, "t4");
        chk("t4 bits0", cap[0], 32'hB);
        chk("t4 bits1", cap[1], 32'h17);

        // three back-to-back words
        do_reset();
        push(4'b1001);
        push(4'b0111);
        push(4'b1100);
        wait_idle(100, "t5");
        chk("t5 bits0", cap[0], 32'h97C);
        chk("t5 bits1", cap[1], 32'h49F8);
        chk("t5 wc", 32'(wc_p), 32'h0303);
        chk("t5 pops1", 32'(npops[1]), 32'd3);

        // reset mid-word
        do_reset();
        push(4'b1011);
        k = 0;
        while (ncap[0] < 2 && k < 20) begin cycle(); k++; end
        chk("t6 midword busy", 32'(bz_v), 32'd3);
        do_reset();
        repeat (10) cycle();
        chk("t6 pops", 32'(npops[0] + npops[1]), 32'd0);
        chk("t6 wc", 32'(wc_p), 32'd0);
        chk("t6 nbits", 32'(ncap[0] + ncap[1]), 32'd0);

        // randomized traffic and backpressure
        do_reset();
        pushed = 0;
        k = 0;
        while (pushed < 200 && k < 6000) begin
            ser_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, (pushed < 100) ? 2 : 9) == 0) begin
                push(4'($urandom_range(0, 15)));
                pushed++;
            end
            cycle();
            k++;
        end
        ser_ready = 1'b1;
        wait_idle(3000, "rand");
        chk("rand pushed", 32'(pushed), 32'd200);
        chk("rand wc", 32'(wc_p), 32'hC8C8);
        chk("rand pops0", 32'(npops[0]), 32'(pushed));

        // 256 words wrap the counter
        do_reset();
        ser_ready = 1'b1;
        repeat (256) push(4'($urandom_range(0, 15)));
        wait_idle(5000, "wrap");
        chk("wrap wc", 32'(wc_p), 32'd0);
        chk("wrap pops0", 32'(npops[0]), 32'd256);
        chk("wrap pops1", 32'(npops[1]), 32'd256);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
